core_regs: RTL and testbench
============================

CORE_REGS -- requirements
Module: core_regs

Interface
REQ-001 The block SHALL have parameter RESET_SP, default 32'h2000_1000, reset value of SP.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, reset value of PC.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 The block SHALL have port ld_rd, input, 1, write strobe for the register at rd_addr.
REQ-006 The block SHALL have port rd_addr, input, 4, destination index R0-R15.
REQ-007 The block SHALL have port wr_data, input, 32, data for every ld_* strobe.
REQ-008 The block SHALL have ports ld_sp, ld_lr, ld_pc, ld_apsr, ld_ipsr and ld_primask, each an input of width 1, each a dedicated write strobe.
REQ-009 The block SHALL have port pc_inc, input, 1, advance PC by 2 (one Thumb halfword).
REQ-010 The block SHALL have ports rn_addr and rm_addr, each an input of width 4, read indices.
REQ-011 The block SHALL have ports rn_data and rm_data, each an output of width 32, read results.
REQ-012 The block SHALL have ports sp, lr and pc, each an output of width 32, live register values.
REQ-013 The block SHALL have port apsr, output, 4, flags N,Z,C,V in bits [3:0].
REQ-014 The block SHALL have port ipsr, output, 6, exception number.
REQ-015 The block SHALL have port primask, output, 1, interrupt mask.

Function
REQ-016 On ld_rd with rd_addr 0-12, Rn SHALL take wr_data at the next edge.
REQ-017 ld_rd with rd_addr 13, 14 or 15 SHALL behave as ld_sp, ld_lr or ld_pc respectively.
REQ-018 SP writes SHALL store {wr_data[31:2],2'b00}; PC writes SHALL store {wr_data[31:1],1'b0}.
REQ-019 Per target, a dedicated strobe SHALL win over an aliased ld_rd in the same cycle; both carry wr_data, so the result is identical and no error is raised.
REQ-020 For PC, priority SHALL be ld_pc/ld_rd(15) over pc_inc over hold.
REQ-021 pc_inc SHALL compute pc+2 modulo 2^32, so 32'hFFFF_FFFE wraps to 0.
REQ-022 ld_apsr SHALL load wr_data[31:28]; ld_ipsr SHALL load wr_data[5:0]; ld_primask SHALL load wr_data[0].
REQ-023 Reads SHALL be combinational: index 0-14 returns the register, and index 15 returns pc+4, the Thumb read-ahead value.
REQ-024 Independent strobes in one cycle SHALL all take effect, including all seven together.
REQ-025 Outputs sp, lr, pc, apsr, ipsr and primask SHALL reflect registered state and update one cycle after the strobe.

Reset
REQ-026 While rst is high, the block SHALL hold R0-R12=0, SP=RESET_SP aligned, LR=32'hFFFF_FFFF, PC=RESET_PC aligned, APSR=0, IPSR=0 and PRIMASK=0.
REQ-027 Reset asserted mid-write SHALL win; the strobe in that cycle SHALL be discarded.
REQ-028 The first write SHALL occur at the first rising edge after rst deasserts.

Configuration
REQ-029 With macro CORE_REGS_BYPASS_EN defined, a read whose index matches a same-cycle write target SHALL return the aligned wr_data combinationally.
REQ-030 The bypass SHALL apply to a PC read only on ld_pc/ld_rd(15), returning aligned wr_data+4.
REQ-031 Without CORE_REGS_BYPASS_EN, reads SHALL return pre-write values and no bypass logic SHALL exist.

Structure
REQ-032 Shared package cm0_pkg SHALL hold REG_SP=13, REG_LR=14, REG_PC=15, APSR bit positions, LR_RESET and register/index width typedefs.
REQ-033 R0-R12 storage and its two read muxes SHALL be a sub-module named core_regs_gpr; special registers and priority logic SHALL stay in core_regs.

Verification
REQ-034 The bench SHALL check: rst pulse after arbitrary writes -> next cycle sp=32'h2000_1000, lr=32'hFFFF_FFFF, pc=0, apsr=0, ipsr=0, primask=0.
REQ-035 The bench SHALL check: ld_rd, rd_addr=5, wr_data=32'hDEAD_BEEF; then rn_addr=5 -> rn_data=32'hDEAD_BEEF; with rm_addr=15 and pc=32'h100 -> rm_data=32'h104.
REQ-036 The bench SHALL check: ld_sp with wr_data=32'h2000_0FFF -> sp=32'h2000_0FFC; ld_pc with 32'h0000_0201 plus pc_inc the same cycle -> pc=32'h200.
REQ-037 The bench SHALL check: pc=32'hFFFF_FFFE, pc_inc -> pc=0.
REQ-038 The bench SHALL check: all seven strobes in one cycle, wr_data=32'hA000_0023 -> apsr=4'hA, ipsr=6'h23, primask=1 and sp, lr and pc all updated.
REQ-039 The bench SHALL check, in the bypass build: ld_rd rd_addr=3 wr_data=32'h55 with rn_addr=3 -> rn_data=32'h55 in the same cycle; in the non-bypass build -> the prior value.

Source files
------------

// File: rtl/cm0_pkg.sv
// rtl/cm0_pkg.sv - shared register-file types, indices and alignment helpers
package cm0_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  reg_idx_t;

  localparam int       NUM_GPR  = 13;
  localparam reg_idx_t LAST_GPR = 4'd12;
  localparam reg_idx_t REG_SP   = 4'd13;
  localparam reg_idx_t REG_LR   = 4'd14;
  localparam reg_idx_t REG_PC   = 4'd15;

  // Flag positions inside an xPSR-format word
  localparam int APSR_N_BIT = 31;
  localparam int APSR_Z_BIT = 30;
  localparam int APSR_C_BIT = 29;
  localparam int APSR_V_BIT = 28;

  localparam word_t LR_RESET      = 32'hFFFF_FFFF;
  localparam word_t PC_READ_AHEAD = 32'd4;
  localparam word_t PC_STEP       = 32'd2;

  function automatic word_t align_sp(word_t v);
    return {v[31:2], 2'b00};
  endfunction

  function automatic word_t align_pc(word_t v);
    return {v[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/core_regs_gpr.sv
// rtl/core_regs_gpr.sv - R0-R12 storage with two combinational read ports
// Indices above R12 read as zero; the top substitutes the special registers.
module core_regs_gpr
  import cm0_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     we,
  input  reg_idx_t waddr,
  input  word_t    wdata,
  input  reg_idx_t rn_addr,
  input  reg_idx_t rm_addr,
  output word_t    rn_data,
  output word_t    rm_data
);

  word_t r [NUM_GPR];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPR; i++) r[i] <= '0;
    end else if (we) begin
      r[waddr] <= wdata;
    end
  end

  assign rn_data = (rn_addr <= LAST_GPR) ? r[rn_addr] : '0;
  assign rm_data = (rm_addr <= LAST_GPR) ? r[rm_addr] : '0;

endmodule

// File: rtl/core_regs.sv
// rtl/core_regs.sv - Cortex-M0 style register file: R0-R12, SP, LR, PC, APSR, IPSR, PRIMASK
// Optional same-cycle write-to-read bypass enabled by macro CORE_REGS_BYPASS_EN.
module core_regs
  import cm0_pkg::*;
#(
  parameter logic [31:0] RESET_SP = 32'h2000_1000,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_rd,
  input  logic [3:0]  rd_addr,
  input  logic [31:0] wr_data,
  input  logic        ld_sp,
  input  logic        ld_lr,
  input  logic        ld_pc,
  input  logic        ld_apsr,
  input  logic        ld_ipsr,
  input  logic        ld_primask,
  input  logic        pc_inc,
  input  logic [3:0]  rn_addr,
  input  logic [3:0]  rm_addr,
  output logic [31:0] rn_data,
  output logic [31:0] rm_data,
  output logic [31:0] sp,
  output logic [31:0] lr,
  output logic [31:0] pc,
  output logic [3:0]  apsr,
  output logic [5:0]  ipsr,
  output logic        primask
);

  logic  gpr_we, sp_we, lr_we, pc_we;
  word_t gpr_rn, gpr_rm, rn_base, rm_base;

  // Aliased ld_rd and dedicated strobes carry the same wr_data, so OR-ing them is the priority
  assign gpr_we = ld_rd && (rd_addr <= LAST_GPR);
  assign sp_we  = ld_sp || (ld_rd && rd_addr == REG_SP);
  assign lr_we  = ld_lr || (ld_rd && rd_addr == REG_LR);
  assign pc_we  = ld_pc || (ld_rd && rd_addr == REG_PC);

  core_regs_gpr u_gpr (
    .clk     (clk),
    .rst     (rst),
    .we      (gpr_we),
    .waddr   (rd_addr),
    .wdata   (wr_data),
    .rn_addr (rn_addr),
    .rm_addr (rm_addr),
    .rn_data (gpr_rn),
    .rm_data (gpr_rm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp      <= align_sp(RESET_SP);
      lr      <= LR_RESET;
      pc      <= align_pc(RESET_PC);
      apsr    <= '0;
      ipsr    <= '0;
      primask <= 1'b0;
    end else begin
      if (sp_we) sp <= align_sp(wr_data);
      if (lr_we) lr <= wr_data;
      if (pc_we)       pc <= align_pc(wr_data);
      else if (pc_inc) pc <= pc + PC_STEP;
      if (ld_apsr)
        apsr <= {wr_data[APSR_N_BIT], wr_data[APSR_Z_BIT], wr_data[APSR_C_BIT], wr_data[APSR_V_BIT]};
      if (ld_ipsr)    ipsr    <= wr_data[5:0];
      if (ld_primask) primask <= wr_data[0];
    end
  end

  function automatic word_t arch_read(reg_idx_t idx, word_t gpr_v, word_t sp_v,
                                      word_t lr_v, word_t pc_v);
    case (idx)
      REG_SP:  return sp_v;
      REG_LR:  return lr_v;
      REG_PC:  return pc_v + PC_READ_AHEAD;
      default: return gpr_v;
    endcase
  endfunction

  assign rn_base = arch_read(rn_addr, gpr_rn, sp, lr, pc);
  assign rm_base = arch_read(rm_addr, gpr_rm, sp, lr, pc);

`ifdef CORE_REGS_BYPASS_EN
  // pc_inc alone does not bypass: only an explicit PC load is forwarded
  function automatic word_t bypass(reg_idx_t idx, word_t base);
    if (idx <= LAST_GPR && gpr_we && rd_addr == idx) return wr_data;
    if (idx == REG_SP && sp_we) return align_sp(wr_data);
    if (idx == REG_LR && lr_we) return wr_data;
    if (idx == REG_PC && pc_we) return align_pc(wr_data) + PC_READ_AHEAD;
    return base;
  endfunction

  assign rn_data = bypass(rn_addr, rn_base);
  assign rm_data = bypass(rm_addr, rm_base);
`else
  assign rn_data = rn_base;
  assign rm_data = rm_base;
`endif

endmodule

// File: tb/tb_core_regs.sv
// tb/tb_core_regs.sv - self-checking bench for core_regs with a behavioural register model
module tb_core_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_rd = 0, ld_sp = 0, ld_lr = 0, ld_pc = 0;
  logic        ld_apsr = 0, ld_ipsr = 0, ld_primask = 0, pc_inc = 0;
  logic [3:0]  rd_addr = 0, rn_addr = 0, rm_addr = 0;
  logic [31:0] wr_data = 0;
  logic [31:0] rn_data, rm_data, sp, lr, pc;
  logic [3:0]  apsr;
  logic [5:0]  ipsr;
  logic        primask;

  int n_checks = 0;
  int n_fail   = 0;

  core_regs dut (
    .clk(clk), .rst(rst), .ld_rd(ld_rd), .rd_addr(rd_addr), .wr_data(wr_data),
    .ld_sp(ld_sp), .ld_lr(ld_lr), .ld_pc(ld_pc), .ld_apsr(ld_apsr), .ld_ipsr(ld_ipsr),
    .ld_primask(ld_primask), .pc_inc(pc_inc), .rn_addr(rn_addr), .rm_addr(rm_addr),
    .rn_data(rn_data), .rm_data(rm_data), .sp(sp), .lr(lr), .pc(pc),
    .apsr(apsr), .ipsr(ipsr), .primask(primask)
  );

  always #5 clk = ~clk;

`ifdef CORE_REGS_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Model: index 0-15 holds R0-R12, SP, LR, PC as architecturally visible values
  logic [31:0] m_r [16];
  logic [31:0] m_next [16];
  bit          m_wr [16];
  logic [3:0]  m_apsr, n_apsr;
  logic [5:0]  m_ipsr, n_ipsr;
  logic        m_prim, n_prim;

  task automatic model_reset();
    for (int i = 0; i < 13; i++) m_r[i] = 0;
    m_r[13] = 32'h2000_1000;
    m_r[14] = 32'hFFFF_FFFF;
    m_r[15] = 32'h0;
    m_apsr = 0; m_ipsr = 0; m_prim = 0;
  endtask

  task automatic model_next();
    for (int i = 0; i < 16; i++) begin m_next[i] = m_r[i]; m_wr[i] = 0; end
    if (ld_rd) begin m_wr[rd_addr] = 1; end
    if (ld_sp) m_wr[13] = 1;
    if (ld_lr) m_wr[14] = 1;
    if (ld_pc) m_wr[15] = 1;
    for (int i = 0; i < 16; i++) if (m_wr[i]) m_next[i] = wr_data;
    if (m_wr[13]) m_next[13] = (wr_data / 4) * 4;
    if (m_wr[15]) m_next[15] = (wr_data / 2) * 2;
    else if (pc_inc) m_next[15] = m_r[15] + 2;
    n_apsr = ld_apsr ? wr_data[31:28] : m_apsr;
    n_ipsr = ld_ipsr ? wr_data[5:0] : m_ipsr;
    n_prim = ld_primask ? wr_data[0] : m_prim;
  endtask

  function automatic logic [31:0] exp_read(logic [3:0] idx);
    if (BYPASS && m_wr[idx]) return (idx == 15) ? m_next[15] + 4 : m_next[idx];
    return (idx == 15) ? m_r[15] + 4 : m_r[idx];
  endfunction

  task automatic idle();
    ld_rd = 0; ld_sp = 0; ld_lr = 0; ld_pc = 0;
    ld_apsr = 0; ld_ipsr = 0; ld_primask = 0; pc_inc = 0;
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    for (int i = 0; i < 16; i++) m_r[i] = m_next[i];
    m_apsr = n_apsr; m_ipsr = n_ipsr; m_prim = n_prim;
    #1;
  endtask

  task automatic load_pc(logic [31:0] v);
    idle(); ld_pc = 1; wr_data = v; tick(); idle();
  endtask

  task automatic test_reset();
    rst = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      ld_rd = 1; rd_addr = 4'($urandom_range(0, 15)); wr_data = $urandom;
      ld_sp = 1; ld_lr = 1; ld_apsr = 1; ld_ipsr = 1; ld_primask = 1; pc_inc = 1;
      @(posedge clk); #1;
    end
    idle();
    rst = 1; #1;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    n_checks++;
    if (sp !== 32'h2000_1000 || lr !== 32'hFFFF_FFFF || pc !== 32'h0 ||
        apsr !== 4'h0 || ipsr !== 6'h0 || primask !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: sp=%h lr=%h pc=%h apsr=%h ipsr=%h primask=%b, required 20001000 ffffffff 00000000 0 00 0",
               sp, lr, pc, apsr, ipsr, primask);
    end
    for (int i = 0; i < 13; i++) begin
      rn_addr = 4'(i); #1;
      n_checks++;
      if (rn_data !== 32'h0) begin
        n_fail++; $display("FAIL reset_gpr R%0d: got %h required 00000000", i, rn_data);
      end
    end
  endtask

  task automatic test_gpr_rw();
    idle(); ld_rd = 1; rd_addr = 5; wr_data = 32'hDEAD_BEEF; tick();
    load_pc(32'h100);
    rn_addr = 5; rm_addr = 15; model_next(); #1;
    n_checks++;
    if (rn_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL gpr_read_r5: got %h required deadbeef", rn_data);
    end
    n_checks++;
    if (rm_data !== 32'h104) begin
      n_fail++; $display("FAIL pc_read_ahead: got %h required 00000104", rm_data);
    end
  endtask

  task automatic test_align();
    idle(); ld_sp = 1; wr_data = 32'h2000_0FFF; tick(); idle();
    n_checks++;
    if (sp !== 32'h2000_0FFC) begin
      n_fail++; $display("FAIL sp_align: got %h required 20000ffc", sp);
    end
    ld_pc = 1; pc_inc = 1; wr_data = 32'h0000_0201; tick(); idle();
    n_checks++;
    if (pc !== 32'h200) begin
      n_fail++; $display("FAIL pc_load_over_inc: got %h required 00000200", pc);
    end
    ld_rd = 1; rd_addr = 14; wr_data = 32'h1234_5677; tick(); idle();
    n_checks++;
    if (lr !== 32'h1234_5677) begin
      n_fail++; $display("FAIL lr_alias: got %h required 12345677", lr);
    end
  endtask

  task automatic test_wrap();
    load_pc(32'hFFFF_FFFE);
    rm_addr = 15; model_next(); #1;
    n_checks++;
    if (rm_data !== 32'h2) begin
      n_fail++; $display("FAIL pc_read_wrap: got %h required 00000002", rm_data);
    end
    pc_inc = 1; tick(); idle();
    n_checks++;
    if (pc !== 32'h0) begin
      n_fail++; $display("FAIL pc_inc_wrap: got %h required 00000000", pc);
    end
  endtask

  task automatic test_all_strobes();
    ld_rd = 1; rd_addr = 7; ld_sp = 1; ld_lr = 1; ld_pc = 1;
    ld_apsr = 1; ld_ipsr = 1; ld_primask = 1; wr_data = 32'hA000_0023;
    tick(); idle();
    rn_addr = 7; #1;
    n_checks++;
    if (apsr !== 4'hA || ipsr !== 6'h23 || primask !== 1'b1) begin
      n_fail++; $display("FAIL all_strobes_psr: apsr=%h ipsr=%h primask=%b required a 23 1", apsr, ipsr, primask);
    end
    n_checks++;
    if (sp !== 32'hA000_0020 || lr !== 32'hA000_0023 || pc !== 32'hA000_0022 || rn_data !== 32'hA000_0023) begin
      n_fail++; $display("FAIL all_strobes_regs: sp=%h lr=%h pc=%h r7=%h required a0000020 a0000023 a0000022 a0000023",
                         sp, lr, pc, rn_data);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    idle(); ld_rd = 1; rd_addr = 3; wr_data = 32'h11; tick();
    wr_data = 32'h55; rn_addr = 3; #1;
    want = BYPASS ? 32'h55 : 32'h11;
    n_checks++;
    if (rn_data !== want) begin
      n_fail++; $display("FAIL bypass_r3: got %h required %h", rn_data, want);
    end
    tick(); idle();
    load_pc(32'h400);
    pc_inc = 1; rm_addr = 15; #1;
    n_checks++;
    if (rm_data !== 32'h404) begin
      n_fail++; $display("FAIL bypass_pc_inc_only: got %h required 00000404", rm_data);
    end
    pc_inc = 0; ld_pc = 1; wr_data = 32'h0000_0803; #1;
    want = BYPASS ? 32'h806 : 32'h404;
    n_checks++;
    if (rm_data !== want) begin
      n_fail++; $display("FAIL bypass_pc_load: got %h required %h", rm_data, want);
    end
    tick(); idle();
  endtask

  task automatic test_reset_midwrite();
    ld_rd = 1; rd_addr = 9; ld_sp = 1; ld_lr = 1; ld_apsr = 1; ld_ipsr = 1;
    ld_primask = 1; wr_data = 32'h7777_7777;
    rst = 1; model_reset();
    @(posedge clk); #1;
    rn_addr = 9;
    n_checks++;
    if (sp !== 32'h2000_1000 || lr !== 32'hFFFF_FFFF || apsr !== 0 || ipsr !== 0 ||
        primask !== 0 || rn_data !== 0) begin
      n_fail++; $display("FAIL reset_midwrite: sp=%h lr=%h apsr=%h ipsr=%h primask=%b r9=%h", sp, lr, apsr, ipsr, primask, rn_data);
    end
    rst = 0;
    tick(); idle();
    n_checks++;
    if (sp !== 32'h7777_7774 || rn_data !== 32'h7777_7777 || ipsr !== 6'h37) begin
      n_fail++; $display("FAIL first_write_after_reset: sp=%h r9=%h ipsr=%h required 77777774 77777777 37", sp, rn_data, ipsr);
    end
  endtask

  task automatic test_random();
    logic [31:0] e_rn, e_rm;
    for (int k = 0; k < 300; k++) begin
      ld_rd = ($urandom_range(0, 2) == 0); rd_addr = 4'($urandom);
      ld_sp = ($urandom_range(0, 5) == 0); ld_lr = ($urandom_range(0, 5) == 0);
      ld_pc = ($urandom_range(0, 7) == 0); pc_inc = ($urandom_range(0, 1) == 0);
      ld_apsr = ($urandom_range(0, 3) == 0); ld_ipsr = ($urandom_range(0, 3) == 0);
      ld_primask = ($urandom_range(0, 3) == 0);
      wr_data = $urandom; rn_addr = 4'($urandom);
      rm_addr = (k % 4 == 0) ? rd_addr : 4'($urandom);
      model_next(); #1;
      e_rn = exp_read(rn_addr); e_rm = exp_read(rm_addr);
      n_checks++;
      if (rn_data !== e_rn || rm_data !== e_rm) begin
        n_fail++; $display("FAIL rand_read[%0d]: rn[%0d]=%h rm[%0d]=%h required %h %h", k, rn_addr, rn_data, rm_addr, rm_data, e_rn, e_rm);
      end
      tick();
      n_checks++;
      if (sp !== m_r[13] || lr !== m_r[14] || pc !== m_r[15] || apsr !== m_apsr ||
          ipsr !== m_ipsr || primask !== m_prim) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: sp=%h lr=%h pc=%h apsr=%h ipsr=%h pm=%b required %h %h %h %h %h %b",
                 k, sp, lr, pc, apsr, ipsr, primask, m_r[13], m_r[14], m_r[15], m_apsr, m_ipsr, m_prim);
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    test_gpr_rw();
    test_align();
    test_wrap();
    test_all_strobes();
    test_bypass();
    test_reset_midwrite();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
